wb_gpio_irq_bank: RTL
=====================

Name: wb_gpio_irq_bank

Overview:
Parametrised Wishbone-slave GPIO bank that drives a configurable, contiguous slice of user I/O pads. It is the generalised successor of the fixed 12-pin peripheral slot in the user project wrapper. It adds:
- per-pin direction control
- input synchronisation
- per-pin edge or level interrupts with sticky write-1-to-clear (W1C) status
- routing of pin interrupts onto NUM_IRQ user_irq lines

It sits directly under user_project_wrapper on the management Wishbone bus.

Parameters:
NUM_PINS, 12, pads handled (1..32)
NUM_IRQ, 3, interrupt output lines (1..3)
SYNC_STAGES, 2, input synchroniser depth (2..4)
ADDR_BASE, 32'h3000_0000, window base address
ADDR_MASK, 32'hFFFF_FFC0, address bits compared against ADDR_BASE (64-byte window)

Ports:
wb_clk_i  in  1  single clock
wb_rst_n_i  in  1  reset, asynchronous assert, active-low
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  NUM_PINS  pad inputs
io_out  out  NUM_PINS  pad output values
io_oeb  out  NUM_PINS  pad output enables, active-low
irq  out  NUM_IRQ  interrupt lines, active-high, registered

Behaviour:
Interface:
- One clock, wb_clk_i.
- Reset wb_rst_n_i is asynchronous and active-low.

Reset values:
- All registers 0.
- wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb all 1 (every pin is an input), irq=0.

Bus selection and acknowledge:
- Slave is selected when cyc & stb & ((adr & ADDR_MASK) == ADDR_BASE).
- When selected and ack=0: ack=1 on the next edge, for exactly one cycle. A new access can therefore be acknowledged at most every other cycle.
- Unselected addresses: no ack; wbs_dat_o is held at 0.
- Writes take effect on the ack edge. wbs_sel_i gates each byte. Bits at or above NUM_PINS are ignored on write and read as 0.
- Read data is registered and valid in the ack cycle.
- Unmapped offsets inside the window: ack is given, read returns 0, write is ignored.

Register map (offset, access):
- 0x00 DATA_IN, RO: synchronised pin values.
- 0x04 DATA_OUT, RW: drives io_out.
- 0x08 DIR, RW: 1 = output; io_oeb = ~DIR.
- 0x0C IRQ_EN, RW.
- 0x10 IRQ_MODE, RW: 0 = edge, 1 = level.
- 0x14 IRQ_POL, RW.
  - Edge mode: 0 = rising, 1 = falling.
  - Level mode: 0 = high, 1 = low.
- 0x18 IRQ_STATUS, W1C.
- 0x20 + 4k IRQ_MASK[k], RW, for k < NUM_IRQ.
- 0x3C ID, RO: {8'h47, 8'(NUM_IRQ), 8'(SYNC_STAGES), 8'(NUM_PINS)}.

Input path:
- Each pin passes through a SYNC_STAGES flop chain, then a prev flop.
- rise = sync & ~prev; fall = ~sync & prev.

Post-reset arming:
- A warm-up counter counts SYNC_STAGES+1 cycles after reset release.
- Edge detection is suppressed until the count completes, so pins that are high at reset produce no spurious edge.

Status update (per bit):
- Edge mode: set on the selected edge. Cleared by W1C.
- Level mode: status equals the live condition every cycle, so W1C has no lasting effect while the condition holds.
- Status is set regardless of IRQ_EN.
- An event and a W1C on the same bit in the same cycle: set wins.

Interrupt output:
- irq[k] <= |(IRQ_STATUS & IRQ_EN & IRQ_MASK[k]).
- Pad edge to irq latency is SYNC_STAGES+2 cycles.

Mode/polarity changes:
- A write to IRQ_MODE or IRQ_POL does not clear status.
- Stale edge status bits remain set until cleared by W1C.

Reset mid-transaction:
- All state clears asynchronously and no ack is issued.
- The master must restart the transfer.

Decomposition:
- Package wb_gpio_pkg: register offset localparams, the ID tag constant 8'h47, and the MODE/POL encodings.
- Sub-module gpio_sync_edge, one instance per pin via generate: synchroniser, prev flop, rise/fall outputs, with an arm input driven by the shared warm-up counter.
- Bus logic, register file, status and irq logic live in the top module.

Test Plan:
1. Reset, then read 0x3C with defaults -> 32'h4703_020C; io_oeb=12'hFFF; irq=0.
2. Write DIR=0x00F and DATA_OUT=0xFFF -> io_oeb=12'hFF0, io_out=12'hFFF; readback of DATA_OUT = 0x00000FFF. A write with sel=4'b0001 updates only bits 7:0.
3. EN[3]=1, MODE[3]=0, POL[3]=0, MASK[1]=0x008; raise io_in[3] -> STATUS=0x008 after SYNC_STAGES+1 cycles, irq[1]=1 one cycle later and irq[0]=irq[2]=0. Write 0x008 to 0x18 -> irq[1]=0 on the next cycle.
4. Level-low on pin 5 with io_in[5]=0; W1C bit 5 -> status bit remains 1. Set io_in[5]=1, then W1C -> status bit clears.
5. W1C of bit 3 in the same cycle that a rising edge on pin 3 is detected -> bit 3 remains set.
6. io_in=0xFFF held through reset -> no status bits set. Access to ADDR_BASE+0x40 -> no ack. Assert wb_rst_n_i low mid-access -> ack stays 0 and all registers read back 0.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO/IRQ bank: register offsets, ID tag,
// and the per-bit MODE/POL encodings.
package wb_gpio_pkg;

  localparam logic [5:0] OFF_DATA_IN  = 6'h00;
  localparam logic [5:0] OFF_DATA_OUT = 6'h04;
  localparam logic [5:0] OFF_DIR      = 6'h08;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h0C;
  localparam logic [5:0] OFF_IRQ_MODE = 6'h10;
  localparam logic [5:0] OFF_IRQ_POL  = 6'h14;
  localparam logic [5:0] OFF_IRQ_STAT = 6'h18;
  localparam logic [5:0] OFF_IRQ_MASK = 6'h20;
  localparam logic [5:0] OFF_ID       = 6'h3C;

  localparam logic [7:0] ID_TAG = 8'h47;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;
  localparam logic POL_RISE_HIGH = 1'b0;
  localparam logic POL_FALL_LOW  = 1'b1;

endpackage

// File: rtl/gpio_sync_edge.sv
// One pad input: synchroniser chain, previous-value flop and gated edge strobes.
module gpio_sync_edge
  import wb_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  input  logic i_arm,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Strobes stay quiet until the chain has flushed its post-reset contents.
  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = i_arm &  o_sync & ~r_prev;
  assign o_fall = i_arm & ~o_sync &  r_prev;

endmodule

// File: rtl/wb_gpio_irq_bank.sv
// Wishbone GPIO bank: direction/data registers, synchronised inputs, sticky
// edge or live level interrupt status routed to NUM_IRQ masked irq lines.
module wb_gpio_irq_bank
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_PINS    = 12,
  parameter int          NUM_IRQ     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFC0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_PINS-1:0] io_in,
  output logic [NUM_PINS-1:0] io_out,
  output logic [NUM_PINS-1:0] io_oeb,
  output logic [NUM_IRQ-1:0]  irq
);

  logic [NUM_PINS-1:0] r_out, r_dir, r_en, r_mode, r_pol, r_status;
  logic [NUM_PINS-1:0] r_mask [NUM_IRQ];
  logic [NUM_IRQ-1:0]  r_irq;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic [2:0]          r_warm;

  logic                w_sel, w_acc, w_wr, w_arm;
  logic [5:0]          w_off;
  logic [31:0]         w_rdata;
  logic [NUM_PINS-1:0] w_wmask, w_wdat, w_w1c, w_status_nxt;
  logic [NUM_PINS-1:0] w_sync, w_rise, w_fall, w_cond, w_evt;
  logic                w_unused;

  assign w_sel = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  assign w_acc = w_sel & ~r_ack;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_off = {wbs_adr_i[5:2], 2'b00};
  assign w_unused = ^{wbs_dat_i, wbs_sel_i};

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < NUM_PINS; i++) w_wmask[i] = wbs_sel_i[i/8];
  end
  assign w_wdat = wbs_dat_i[NUM_PINS-1:0];

  function automatic logic [NUM_PINS-1:0] f_merge(input logic [NUM_PINS-1:0] old_v,
                                                  input logic [NUM_PINS-1:0] new_v,
                                                  input logic [NUM_PINS-1:0] msk);
    return (old_v & ~msk) | (new_v & msk);
  endfunction

  // Warm-up down-counter: arms edge detection once the synchronisers are flushed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)          r_warm <= 3'(SYNC_STAGES + 1);
    else if (r_warm != 3'd0)  r_warm <= r_warm - 3'd1;
  end
  assign w_arm = (r_warm == 3'd0);

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (wb_clk_i),
      .i_rst_n(wb_rst_n_i),
      .i_pin  (io_in[g]),
      .i_arm  (w_arm),
      .o_sync (w_sync[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_en   <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      for (int k = 0; k < NUM_IRQ; k++) r_mask[k] <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_DATA_OUT: r_out  <= f_merge(r_out,  w_wdat, w_wmask);
        OFF_DIR:      r_dir  <= f_merge(r_dir,  w_wdat, w_wmask);
        OFF_IRQ_EN:   r_en   <= f_merge(r_en,   w_wdat, w_wmask);
        OFF_IRQ_MODE: r_mode <= f_merge(r_mode, w_wdat, w_wmask);
        OFF_IRQ_POL:  r_pol  <= f_merge(r_pol,  w_wdat, w_wmask);
        default: ;
      endcase
      for (int k = 0; k < NUM_IRQ; k++)
        if (w_off == OFF_IRQ_MASK + 6'(4*k)) r_mask[k] <= f_merge(r_mask[k], w_wdat, w_wmask);
    end
  end

  // Level bits track the live condition; edge bits are sticky and an event beats W1C.
  assign w_cond = w_sync ^ r_pol;
  assign w_evt  = (r_pol & w_fall) | (~r_pol & w_rise);
  assign w_w1c  = (w_wr && w_off == OFF_IRQ_STAT) ? (w_wdat & w_wmask) : '0;
  assign w_status_nxt = (r_mode & w_cond) | (~r_mode & ((r_status & ~w_w1c) | w_evt));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_status <= '0;
      r_irq    <= '0;
    end else begin
      r_status <= w_status_nxt;
      for (int k = 0; k < NUM_IRQ; k++) r_irq[k] <= |(r_status & r_en & r_mask[k]);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_DATA_IN:  w_rdata = 32'(w_sync);
      OFF_DATA_OUT: w_rdata = 32'(r_out);
      OFF_DIR:      w_rdata = 32'(r_dir);
      OFF_IRQ_EN:   w_rdata = 32'(r_en);
      OFF_IRQ_MODE: w_rdata = 32'(r_mode);
      OFF_IRQ_POL:  w_rdata = 32'(r_pol);
      OFF_IRQ_STAT: w_rdata = 32'(r_status);
      OFF_ID:       w_rdata = {ID_TAG, 8'(NUM_IRQ), 8'(SYNC_STAGES), 8'(NUM_PINS)};
      default: ;
    endcase
    for (int k = 0; k < NUM_IRQ; k++)
      if (w_off == OFF_IRQ_MASK + 6'(4*k)) w_rdata = 32'(r_mask[k]);
  end

  // Read data is only non-zero during the single ack cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out;
  assign io_oeb    = ~r_dir;
  assign irq       = r_irq;

endmodule
